// File: rtl/TaskInjectorPkg.sv
// Shared definitions for the link hang injector / stall monitor pair.
package TaskInjectorPkg;

  localparam int unsigned FLIT_W    = 32;
  localparam int unsigned SERVICE_W = 8;
  localparam int unsigned NODE_W    = 16;
  localparam int unsigned CNT_W     = 32;

  // Service code carried in header bits [23:16] for message delivery packets.
  localparam logic [SERVICE_W-1:0] MESSAGE_DELIVERY = 8'h01;

  // Packet parsing position of the stall monitor.
  typedef enum logic [2:0] {
    HEADER    = 3'd0,
    SRCPE     = 3'd1,
    EDGE      = 3'd2,
    TIMESTAMP = 3'd3,
    BODY      = 3'd4
  } lsm_fsm_t;

endpackage

// File: rtl/link_gap_counter.sv
// Saturating in-packet gap counter with per-packet maximum tracking.
module link_gap_counter #(
  parameter int unsigned GAP_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             active_i,
  output logic [GAP_W-1:0] gap_o,
  output logic [GAP_W-1:0] max_o
);

  // Count idle cycles between accepted flits; fold each finished gap into the max.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      gap_o <= '0;
      max_o <= '0;
    end else if (!active_i) begin
      gap_o <= '0;
    end else if (enable_i) begin
      gap_o <= '0;
      if (gap_o > max_o) max_o <= gap_o;
    end else if (gap_o != '1) begin
      gap_o <= gap_o + GAP_W'(1);
    end
  end

endmodule

// File: rtl/link_stall_monitor.sv
// Passive link stall monitor: transparent flit pass-through, in-packet gap
// measurement and one event per stalled message delivery packet.
// Optional CSV event trace is compiled in with `define LINK_MON_LOG_EN.
module link_stall_monitor
  import TaskInjectorPkg::*;
#(
  parameter logic [15:0] ADDRESS   = 16'b0,
  parameter string       PORT      = "",
  parameter int unsigned THRESHOLD = 64,
  parameter int unsigned GAP_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tx_i,
  output logic              cr_tx_o,
  input  logic              eop_tx_i,
  input  logic [31:0]       data_tx_i,
  output logic              rx_o,
  input  logic              cr_rx_i,
  output logic              eop_rx_o,
  output logic [31:0]       data_rx_o,
  output logic              evt_valid_o,
  output logic [15:0]       evt_sender_o,
  output logic [15:0]       evt_receiver_o,
  output logic [31:0]       evt_timestamp_o,
  output logic [GAP_W-1:0]  evt_gap_o,
  output logic              stalled_o,
  output logic [31:0]       pkt_count_o,
  output logic [31:0]       stall_count_o
);

  lsm_fsm_t                 state_q, state_d;
  logic                     xfer;
  logic [SERVICE_W-1:0]     service_q;
  logic [NODE_W-1:0]        sender_q, receiver_q;
  logic [FLIT_W-1:0]        timestamp_q;
  logic [GAP_W-1:0]         gap, max_gap, final_gap;
  logic                     pkt_done, stall_hit;

  // Zero-latency pass-through; the monitor never back-pressures.
  assign xfer      = tx_i & cr_rx_i;
  assign rx_o      = tx_i;
  assign cr_tx_o   = cr_rx_i;
  assign eop_rx_o  = eop_tx_i;
  assign data_rx_o = data_tx_i;

  // Parser state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= HEADER;
    else       state_q <= state_d;
  end

  // Parser next-state: advance one field per accepted flit, eop always resyncs.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      case (state_q)
        HEADER:    state_d = eop_tx_i ? HEADER : SRCPE;
        SRCPE: begin
          if (eop_tx_i)                            state_d = HEADER;
          else if (service_q == MESSAGE_DELIVERY)  state_d = EDGE;
          else                                     state_d = BODY;
        end
        EDGE:      state_d = eop_tx_i ? HEADER : TIMESTAMP;
        TIMESTAMP: state_d = eop_tx_i ? HEADER : BODY;
        BODY:      state_d = eop_tx_i ? HEADER : BODY;
        default:   state_d = HEADER;
      endcase
    end
  end

  // Capture header service, edge and timestamp fields of the current packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      service_q   <= '0;
      sender_q    <= '0;
      receiver_q  <= '0;
      timestamp_q <= '0;
    end else if (xfer) begin
      if (state_q == HEADER)    service_q   <= data_tx_i[23:16];
      if (state_q == EDGE)      {sender_q, receiver_q} <= data_tx_i;
      if (state_q == TIMESTAMP) timestamp_q <= data_tx_i;
    end
  end

  link_gap_counter #(
    .GAP_W (GAP_W)
  ) u_gap (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (xfer && (state_q == HEADER)),
    .enable_i (xfer),
    .active_i (state_q != HEADER),
    .gap_o    (gap),
    .max_o    (max_gap)
  );

  // The closing gap counts toward the packet's worst gap.
  assign final_gap = (gap > max_gap) ? gap : max_gap;
  assign pkt_done  = xfer && eop_tx_i && (state_q == BODY) &&
                     (service_q == MESSAGE_DELIVERY);
  assign stall_hit = pkt_done && (32'(final_gap) >= 32'(THRESHOLD));

  // Event, stall level and statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_valid_o     <= 1'b0;
      evt_sender_o    <= '0;
      evt_receiver_o  <= '0;
      evt_timestamp_o <= '0;
      evt_gap_o       <= '0;
      stalled_o       <= 1'b0;
      pkt_count_o     <= '0;
      stall_count_o   <= '0;
    end else begin
      evt_valid_o <= stall_hit;
      stalled_o   <= (state_q != HEADER) && (32'(gap) >= 32'(THRESHOLD));
      if (pkt_done) pkt_count_o <= pkt_count_o + 32'd1;
      if (stall_hit) begin
        evt_sender_o    <= sender_q;
        evt_receiver_o  <= receiver_q;
        evt_timestamp_o <= timestamp_q;
        evt_gap_o       <= final_gap;
        stall_count_o   <= stall_count_o + 32'd1;
      end
    end
  end

`ifdef LINK_MON_LOG_EN
  // One CSV line per emitted event, tagged with the monitor's log name.
  always @(posedge clk_i) begin
    if (evt_valid_o)
      $display("lm%0dx%0d-%s: %0d,%0d,%0d,%0d,%0d", ADDRESS[15:8], ADDRESS[7:0],
               PORT, evt_timestamp_o, $time / 10, evt_sender_o, evt_receiver_o,
               evt_gap_o);
  end
`endif

endmodule

// File: tb/tb_link_stall_monitor.sv
// Randomized bench for link_stall_monitor against a packet-level model.
// Two instances run on identical stimulus: default sizing and a 4-bit gap.
module tb_link_stall_monitor;
  import TaskInjectorPkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        tx_i = 1'b0, eop_tx_i = 1'b0, cr_rx_i = 1'b0;
  logic [31:0] data_tx_i = '0;

  logic        cr16, rx16, eop16, ev16, st16;
  logic [31:0] d16, ts16, pc16, sc16;
  logic [15:0] snd16, rcv16, gap16;
  logic        cr4, rx4, eop4, ev4, st4;
  logic [31:0] d4, ts4, pc4, sc4;
  logic [15:0] snd4, rcv4;
  logic [3:0]  gap4;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  link_stall_monitor #(.ADDRESS(16'h0102), .PORT("n"), .THRESHOLD(64), .GAP_W(16)) dut16 (
    .clk_i(clk_i), .rst_i(rst_i), .tx_i(tx_i), .cr_tx_o(cr16), .eop_tx_i(eop_tx_i),
    .data_tx_i(data_tx_i), .rx_o(rx16), .cr_rx_i(cr_rx_i), .eop_rx_o(eop16),
    .data_rx_o(d16), .evt_valid_o(ev16), .evt_sender_o(snd16), .evt_receiver_o(rcv16),
    .evt_timestamp_o(ts16), .evt_gap_o(gap16), .stalled_o(st16),
    .pkt_count_o(pc16), .stall_count_o(sc16));

  link_stall_monitor #(.ADDRESS(16'h0304), .PORT("s"), .THRESHOLD(10), .GAP_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .tx_i(tx_i), .cr_tx_o(cr4), .eop_tx_i(eop_tx_i),
    .data_tx_i(data_tx_i), .rx_o(rx4), .cr_rx_i(cr_rx_i), .eop_rx_o(eop4),
    .data_rx_o(d4), .evt_valid_o(ev4), .evt_sender_o(snd4), .evt_receiver_o(rcv4),
    .evt_timestamp_o(ts4), .evt_gap_o(gap4), .stalled_o(st4),
    .pkt_count_o(pc4), .stall_count_o(sc4));

  // ---------------- reference model (packet level) ----------------
  int          th[2]  = '{64, 10};
  int          smax[2] = '{65535, 15};
  int          idx, gap, maxg;             // flit position in packet, unsaturated gaps
  logic [7:0]  svc;
  logic [15:0] m_snd, m_rcv;
  logic [31:0] m_ts;
  int          exp_pkt;
  logic        exp_ev[2], exp_st[2];
  logic [15:0] exp_snd[2], exp_rcv[2];
  logic [31:0] exp_ts[2];
  int          exp_gap[2], exp_stall[2];

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    idx = 0; gap = 0; maxg = 0; svc = '0; m_snd = '0; m_rcv = '0; m_ts = '0;
    exp_pkt = 0;
    for (int m = 0; m < 2; m++) begin
      exp_ev[m] = 0; exp_st[m] = 0; exp_snd[m] = '0; exp_rcv[m] = '0;
      exp_ts[m] = '0; exp_gap[m] = 0; exp_stall[m] = 0;
    end
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    int fin;
    if (rst_i) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      exp_st[m] = (idx != 0) && (sat(gap, smax[m]) >= th[m]);
      exp_ev[m] = 0;
    end
    if (tx_i && cr_rx_i) begin
      if (idx == 0) begin
        svc = data_tx_i[23:16]; gap = 0; maxg = 0;
      end else begin
        fin = (gap > maxg) ? gap : maxg;
        if (svc == MESSAGE_DELIVERY && idx == 2) {m_snd, m_rcv} = data_tx_i;
        if (svc == MESSAGE_DELIVERY && idx == 3) m_ts = data_tx_i;
        if (eop_tx_i && svc == MESSAGE_DELIVERY && idx >= 4) begin
          exp_pkt++;
          for (int m = 0; m < 2; m++) begin
            if (sat(fin, smax[m]) >= th[m]) begin
              exp_ev[m] = 1; exp_snd[m] = m_snd; exp_rcv[m] = m_rcv;
              exp_ts[m] = m_ts; exp_gap[m] = sat(fin, smax[m]); exp_stall[m]++;
            end
          end
        end
        maxg = fin; gap = 0;
      end
      idx = eop_tx_i ? 0 : ((idx < 4) ? idx + 1 : 4);
    end else if (idx != 0) begin
      gap++;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("g16.evt_valid", 64'(ev16), 64'(exp_ev[0]));
    check("g16.stalled",   64'(st16), 64'(exp_st[0]));
    check("g16.sender",    64'(snd16), 64'(exp_snd[0]));
    check("g16.receiver",  64'(rcv16), 64'(exp_rcv[0]));
    check("g16.timestamp", 64'(ts16), 64'(exp_ts[0]));
    check("g16.gap",       64'(gap16), 64'(exp_gap[0]));
    check("g16.pkt_count", 64'(pc16), 64'(exp_pkt));
    check("g16.stall_cnt", 64'(sc16), 64'(exp_stall[0]));
    check("g4.evt_valid",  64'(ev4), 64'(exp_ev[1]));
    check("g4.stalled",    64'(st4), 64'(exp_st[1]));
    check("g4.sender",     64'(snd4), 64'(exp_snd[1]));
    check("g4.receiver",   64'(rcv4), 64'(exp_rcv[1]));
    check("g4.timestamp",  64'(ts4), 64'(exp_ts[1]));
    check("g4.gap",        64'(gap4), 64'(exp_gap[1]));
    check("g4.pkt_count",  64'(pc4), 64'(exp_pkt));
    check("g4.stall_cnt",  64'(sc4), 64'(exp_stall[1]));
  endtask

  // One clock: drive at negedge, check pass-through, step model, check registers.
  task automatic cycle(input logic tx, input logic cr, input logic eop,
                       input logic [31:0] d, input logic rst);
    logic [34:0] drv;
    @(negedge clk_i);
    tx_i = tx; cr_rx_i = cr; eop_tx_i = eop; data_tx_i = d; rst_i = rst;
    drv = {tx, cr, eop, d};
    #1;
    check("g16.passthru", 64'({rx16, cr16, eop16, d16}), 64'(drv));
    check("g4.passthru",  64'({rx4, cr4, eop4, d4}), 64'(drv));
    @(posedge clk_i);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
  endtask

  function automatic int rand_pre();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 0;
    if (r < 90) return $urandom_range(1, 4);
    return $urandom_range(12, 90);
  endfunction

  // Send one packet; flit long_at is preceded by long_len stall cycles.
  // A reset cycle replaces flit abort_at when abort_at >= 0.
  task automatic send_pkt(input logic [7:0] s, input logic [31:0] edge_w,
                          input logic [31:0] ts, input int n, input int long_at,
                          input int long_len, input bit rnd, input int abort_at);
    logic [31:0] d;
    int pre;
    for (int f = 0; f < n; f++) begin
      if (f == abort_at) begin
        cycle(1'b1, 1'b1, 1'b0, $urandom, 1'b1);
        return;
      end
      case (f)
        0:       d = {8'h00, s, 16'h0000};
        2:       d = edge_w;
        3:       d = ts;
        default: d = $urandom;
      endcase
      pre = (f == long_at) ? long_len : (rnd ? rand_pre() : 0);
      for (int p = 0; p < pre; p++) begin
        if ($urandom_range(0, 1) != 0) cycle(1'b1, 1'b0, (f == n - 1), d, 1'b0);
        else                           idle_cycle();
      end
      cycle(1'b1, 1'b1, (f == n - 1), d, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] s;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Back-to-back delivery packet: counted, no event.
    send_pkt(MESSAGE_DELIVERY, 32'h0102_0304, 32'd1000, 6, -1, 0, 1'b0, -1);
    check("t1.pkt_count", 64'(pc16), 64'd1);
    check("t1.stall_cnt", 64'(sc16), 64'd0);

    // 70-cycle stall before the first payload flit: event with gap 70.
    send_pkt(MESSAGE_DELIVERY, 32'h0102_0304, 32'd1000, 6, 4, 70, 1'b0, -1);
    check("t2.evt_valid", 64'(ev16), 64'd1);
    check("t2.sender",    64'(snd16), 64'h0102);
    check("t2.receiver",  64'(rcv16), 64'h0304);
    check("t2.timestamp", 64'(ts16), 64'd1000);
    check("t2.gap",       64'(gap16), 64'd70);
    idle_cycle();
    check("t2.evt_pulse", 64'(ev16), 64'd0);

    // Non-delivery service with a 100-cycle stall: no event, no count.
    send_pkt(8'h05, 32'hdead_beef, 32'd7, 6, 3, 100, 1'b0, -1);
    check("t3.pkt_count", 64'(pc16), 64'd2);
    check("t3.stall_cnt", 64'(sc16), 64'd1);

    // Long idle between packets is never counted.
    for (int i = 0; i < 200; i++) idle_cycle();
    send_pkt(MESSAGE_DELIVERY, 32'h0a0b_0c0d, 32'd55, 5, -1, 0, 1'b0, -1);
    check("t4.stall_cnt", 64'(sc16), 64'd1);

    // 40-cycle stall: only the narrow instance fires, with a saturated gap.
    send_pkt(MESSAGE_DELIVERY, 32'h1111_2222, 32'd99, 6, 5, 40, 1'b0, -1);
    check("t5.g4_valid", 64'(ev4), 64'd1);
    check("t5.g4_gap",   64'(gap4), 64'd15);
    check("t5.g16_valid", 64'(ev16), 64'd0);

    // Reset while in the packet body, then a clean packet.
    send_pkt(MESSAGE_DELIVERY, 32'h3333_4444, 32'd5, 8, 5, 20, 1'b0, 6);
    check("t6.pkt_count", 64'(pc16), 64'd0);
    send_pkt(MESSAGE_DELIVERY, 32'h5555_6666, 32'd77, 6, 4, 66, 1'b0, -1);
    check("t6.sender", 64'(snd16), 64'h5555);
    check("t6.gap",    64'(gap16), 64'd66);

    // Randomized traffic.
    for (int k = 0; k < 80; k++) begin
      s = ($urandom_range(0, 9) < 7) ? MESSAGE_DELIVERY : 8'($urandom_range(2, 255));
      send_pkt(s, $urandom, $urandom, $urandom_range(1, 9), -1, 0, 1'b1,
               ($urandom_range(0, 14) == 0) ? $urandom_range(1, 8) : -1);
      for (int i = $urandom_range(0, 5); i > 0; i--) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
